// File: rtl/mc_pkg.sv
// Shared encodings for the MIPS32 multicycle control unit: states, opcodes,
// function codes, ALU operation codes and datapath mux selects.
package mc_pkg;

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EXE  = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0100;
   localparam logic [3:0] ALU_AND  = 4'b0001;
   localparam logic [3:0] ALU_OR   = 4'b0101;
   localparam logic [3:0] ALU_XOR  = 4'b0010;
   localparam logic [3:0] ALU_LUI  = 4'b0110;
   localparam logic [3:0] ALU_SLL  = 4'b0011;
   localparam logic [3:0] ALU_SRL  = 4'b0111;
   localparam logic [3:0] ALU_SRA  = 4'b1111;

   localparam logic [1:0] SRCB_RT   = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_BR   = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_RS     = 2'b10;
   localparam logic [1:0] PC_JUMP   = 2'b11;

   typedef struct packed {
      logic i_add;
      logic i_sub;
      logic i_and;
      logic i_or;
      logic i_xor;
      logic i_sll;
      logic i_srl;
      logic i_sra;
      logic i_jr;
      logic i_addi;
      logic i_andi;
      logic i_ori;
      logic i_xori;
      logic i_lw;
      logic i_sw;
      logic i_beq;
      logic i_bne;
      logic i_lui;
      logic i_j;
      logic i_jal;
   } inst_t;

   // ALU operation used in sEXE; branches override this with SUB.
   function automatic logic [3:0] alu_code(inst_t i);
      logic [3:0] c;
      c = ALU_ADD;
      if (i.i_sub)                c = ALU_SUB;
      if (i.i_and  || i.i_andi)   c = ALU_AND;
      if (i.i_or   || i.i_ori)    c = ALU_OR;
      if (i.i_xor  || i.i_xori)   c = ALU_XOR;
      if (i.i_lui)                c = ALU_LUI;
      if (i.i_sll)                c = ALU_SLL;
      if (i.i_srl)                c = ALU_SRL;
      if (i.i_sra)                c = ALU_SRA;
      return c;
   endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: op/func to one-hot instruction flags.
// No state, zero latency; anything not recognised raises ill.
module mc_decode
   import mc_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] func,
   output inst_t      inst,
   output logic       ill,
   output logic       is_rtype,
   output logic       is_itype
);

   always_comb begin
      inst = '0;
      if (op == OP_RTYPE) begin
         case (func)
            FN_ADD:  inst.i_add = 1'b1;
            FN_SUB:  inst.i_sub = 1'b1;
            FN_AND:  inst.i_and = 1'b1;
            FN_OR:   inst.i_or  = 1'b1;
            FN_XOR:  inst.i_xor = 1'b1;
            FN_SLL:  inst.i_sll = 1'b1;
            FN_SRL:  inst.i_srl = 1'b1;
            FN_SRA:  inst.i_sra = 1'b1;
            FN_JR:   inst.i_jr  = 1'b1;
            default: inst = '0;
         endcase
      end else begin
         case (op)
            OP_J:    inst.i_j    = 1'b1;
            OP_JAL:  inst.i_jal  = 1'b1;
            OP_BEQ:  inst.i_beq  = 1'b1;
            OP_BNE:  inst.i_bne  = 1'b1;
            OP_ADDI: inst.i_addi = 1'b1;
            OP_ANDI: inst.i_andi = 1'b1;
            OP_ORI:  inst.i_ori  = 1'b1;
            OP_XORI: inst.i_xori = 1'b1;
            OP_LUI:  inst.i_lui  = 1'b1;
            OP_LW:   inst.i_lw   = 1'b1;
            OP_SW:   inst.i_sw   = 1'b1;
            default: inst = '0;
         endcase
      end
   end

   assign ill      = ~|inst;
   assign is_rtype = inst.i_add | inst.i_sub | inst.i_and | inst.i_or | inst.i_xor |
                     inst.i_sll | inst.i_srl | inst.i_sra | inst.i_jr;
   // Branches compare rs with rt, so they take the register B operand, not the immediate.
   assign is_itype = inst.i_addi | inst.i_andi | inst.i_ori | inst.i_xori |
                     inst.i_lui  | inst.i_lw   | inst.i_sw;

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS32 control FSM: sequences IF/ID/EXE/MEM/WB for a shared ALU and memory.
// Outputs are combinational from state/op/func/z; no backpressure, CPI 2..5 per instruction.
module mc_ctrl
   import mc_pkg::*;
#(
   parameter bit ILL_TRAP = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic [5:0] func,
   input  logic       z,
   output logic       wpc,
   output logic       wir,
   output logic       wmem,
   output logic       wreg,
   output logic       iord,
   output logic       regrt,
   output logic       m2reg,
   output logic       jal,
   output logic       shift,
   output logic       sext,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [3:0] aluc,
   output logic [1:0] pcsource,
   output logic [2:0] state,
   output logic       ill
);

   state_t cur_state;
   state_t nxt_state;
   inst_t  inst;
   logic   dec_ill;
   logic   is_rtype;
   logic   is_itype;

   mc_decode u_decode (
      .op       (op),
      .func     (func),
      .inst     (inst),
      .ill      (dec_ill),
      .is_rtype (is_rtype),
      .is_itype (is_itype)
   );

   always_ff @(posedge clk) begin
      if (rst) cur_state <= S_IF;
      else     cur_state <= nxt_state;
   end

   assign state = cur_state;

   always_comb begin
      nxt_state = cur_state;
      wpc       = 1'b0;
      wir       = 1'b0;
      wmem      = 1'b0;
      wreg      = 1'b0;
      iord      = 1'b0;
      regrt     = 1'b0;
      m2reg     = 1'b0;
      jal       = 1'b0;
      shift     = 1'b0;
      sext      = 1'b0;
      alusrca   = 1'b0;
      alusrcb   = SRCB_RT;
      aluc      = ALU_ADD;
      pcsource  = PC_ALU;
      ill       = 1'b0;

      case (cur_state)
         S_IF: begin
            wpc       = 1'b1;
            wir       = 1'b1;
            alusrcb   = SRCB_FOUR;
            nxt_state = S_ID;
         end
         S_ID: begin
            // Branch target is computed speculatively into ALU-out every decode.
            alusrcb = SRCB_BR;
            sext    = 1'b1;
            if (inst.i_j || inst.i_jal) begin
               wpc       = 1'b1;
               pcsource  = PC_JUMP;
               wreg      = inst.i_jal;
               jal       = inst.i_jal;
               nxt_state = S_IF;
            end else if (inst.i_jr) begin
               wpc       = 1'b1;
               pcsource  = PC_RS;
               nxt_state = S_IF;
            end else if (dec_ill) begin
               ill       = 1'b1;
               nxt_state = ILL_TRAP ? S_HALT : S_IF;
            end else begin
               nxt_state = S_EXE;
            end
         end
         S_EXE: begin
            alusrca = 1'b1;
            shift   = inst.i_sll | inst.i_srl | inst.i_sra;
            alusrcb = is_itype ? SRCB_IMM : SRCB_RT;
            sext    = inst.i_addi | inst.i_lw | inst.i_sw | inst.i_beq | inst.i_bne;
            aluc    = alu_code(inst);
            if (inst.i_beq || inst.i_bne) begin
               aluc      = ALU_SUB;
               pcsource  = PC_ALUOUT;
               wpc       = (inst.i_beq & z) | (inst.i_bne & ~z);
               nxt_state = S_IF;
            end else if (inst.i_lw || inst.i_sw) begin
               nxt_state = S_MEM;
            end else begin
               nxt_state = S_WB;
            end
         end
         S_MEM: begin
            iord = 1'b1;
            if (inst.i_sw) begin
               wmem      = 1'b1;
               nxt_state = S_IF;
            end else begin
               nxt_state = S_WB;
            end
         end
         S_WB: begin
            wreg      = 1'b1;
            regrt     = is_itype;
            m2reg     = inst.i_lw;
            nxt_state = S_IF;
         end
         S_HALT: nxt_state = S_HALT;
         default: nxt_state = S_IF;
      endcase

      // Reset aborts whatever is in flight without letting a write escape.
      if (rst) begin
         wpc  = 1'b0;
         wir  = 1'b0;
         wmem = 1'b0;
         wreg = 1'b0;
         ill  = 1'b0;
      end
   end

   logic unused_ok;
   assign unused_ok = is_rtype;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: one instance with ILL_TRAP=0, one with ILL_TRAP=1,
// sharing stimulus; expected values are hand-derived from the instruction timing.
module tb_mc_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] op;
   logic [5:0] func;
   logic       z;

   logic       wpc0, wir0, wmem0, wreg0, iord0, regrt0, m2reg0, jal0, shift0, sext0, alusrca0, ill0;
   logic [1:0] alusrcb0, pcsource0;
   logic [3:0] aluc0;
   logic [2:0] state0;

   logic       wpc1, wir1, wmem1, wreg1, iord1, regrt1, m2reg1, jal1, shift1, sext1, alusrca1, ill1;
   logic [1:0] alusrcb1, pcsource1;
   logic [3:0] aluc1;
   logic [2:0] state1;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   mc_ctrl #(.ILL_TRAP(1'b0)) u0 (
      .clk(clk), .rst(rst), .op(op), .func(func), .z(z),
      .wpc(wpc0), .wir(wir0), .wmem(wmem0), .wreg(wreg0), .iord(iord0),
      .regrt(regrt0), .m2reg(m2reg0), .jal(jal0), .shift(shift0), .sext(sext0),
      .alusrca(alusrca0), .alusrcb(alusrcb0), .aluc(aluc0), .pcsource(pcsource0),
      .state(state0), .ill(ill0)
   );

   mc_ctrl #(.ILL_TRAP(1'b1)) u1 (
      .clk(clk), .rst(rst), .op(op), .func(func), .z(z),
      .wpc(wpc1), .wir(wir1), .wmem(wmem1), .wreg(wreg1), .iord(iord1),
      .regrt(regrt1), .m2reg(m2reg1), .jal(jal1), .shift(shift1), .sext(sext1),
      .alusrca(alusrca1), .alusrcb(alusrcb1), .aluc(aluc1), .pcsource(pcsource1),
      .state(state1), .ill(ill1)
   );

   wire [3:0] en0 = {wpc0, wir0, wmem0, wreg0};
   wire [3:0] en1 = {wpc1, wir1, wmem1, wreg1};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; op = 6'h00; func = 6'h00; z = 1'b0;
      tick(); tick();
      chk("rst_state", state0, 0);
      chk("rst_en", en0, 4'b0000);
      chk("rst_ill", ill0, 0);
      rst = 1'b0; #1;
      chk("if_en", en0, 4'b1100);
      chk("if_srcb", alusrcb0, 2'b01);
      chk("if_pcsrc", pcsource0, 2'b00);
      chk("if_iord", iord0, 0);

      // add
      op = 6'h00; func = 6'h20;
      tick(); chk("add_s1", state0, 1); chk("add_id_srcb", alusrcb0, 2'b11); chk("add_id_sext", sext0, 1);
      tick(); chk("add_s2", state0, 2); chk("add_aluc", aluc0, 4'b0000); chk("add_srcb", alusrcb0, 2'b00);
              chk("add_srca", alusrca0, 1);
      tick(); chk("add_s4", state0, 4); chk("add_wreg", wreg0, 1); chk("add_regrt", regrt0, 0);
              chk("add_m2reg", m2reg0, 0);
      tick(); chk("add_s0", state0, 0);

      // lw
      op = 6'h23;
      tick(); tick();
      chk("lw_s2", state0, 2); chk("lw_srcb", alusrcb0, 2'b10); chk("lw_sext", sext0, 1); chk("lw_aluc", aluc0, 4'b0000);
      tick(); chk("lw_s3", state0, 3); chk("lw_iord", iord0, 1); chk("lw_wmem", wmem0, 0);
      tick(); chk("lw_s4", state0, 4); chk("lw_m2reg", m2reg0, 1); chk("lw_regrt", regrt0, 1); chk("lw_wreg", wreg0, 1);
      tick(); chk("lw_s0", state0, 0);

      // sw
      op = 6'h2B;
      tick(); tick(); chk("sw_exe_wmem", wmem0, 0);
      tick(); chk("sw_s3", state0, 3); chk("sw_wmem", wmem0, 1); chk("sw_iord", iord0, 1); chk("sw_wreg", wreg0, 0);
      tick(); chk("sw_s0", state0, 0);

      // beq taken, beq not taken, bne taken / not taken
      op = 6'h04; z = 1'b1;
      tick(); tick(); chk("beq_t_wpc", wpc0, 1); chk("beq_pcsrc", pcsource0, 2'b01); chk("beq_aluc", aluc0, 4'b0100);
      tick(); chk("beq_s0", state0, 0);
      z = 1'b0;
      tick(); tick(); chk("beq_nt_wpc", wpc0, 0);
      tick();
      op = 6'h05;
      tick(); tick(); chk("bne_t_wpc", wpc0, 1); chk("bne_pcsrc", pcsource0, 2'b01); chk("bne_aluc", aluc0, 4'b0100);
      z = 1'b1; #1; chk("bne_nt_wpc", wpc0, 0);
      tick(); chk("bne_s0", state0, 0);

      // jal, jr
      op = 6'h03;
      tick(); chk("jal_s1", state0, 1);
      chk("jal_en", {wpc0, wreg0, jal0}, 3'b111); chk("jal_pcsrc", pcsource0, 2'b11);
      tick(); chk("jal_s0", state0, 0);
      op = 6'h00; func = 6'h08;
      tick(); chk("jr_wpc", wpc0, 1); chk("jr_pcsrc", pcsource0, 2'b10); chk("jr_wreg", wreg0, 0);
      tick(); chk("jr_s0", state0, 0);

      // sra, lui
      func = 6'h03;
      tick(); tick(); chk("sra_shift", shift0, 1); chk("sra_aluc", aluc0, 4'b1111); chk("sra_srcb", alusrcb0, 2'b00);
      tick(); tick();
      op = 6'h0F;
      tick(); tick(); chk("lui_aluc", aluc0, 4'b0110); chk("lui_sext", sext0, 0); chk("lui_srcb", alusrcb0, 2'b10);
      tick(); chk("lui_regrt", regrt0, 1); chk("lui_m2reg", m2reg0, 0);
      tick(); chk("lui_s0", state0, 0);

      // reset held 3 cycles in the middle of lw
      op = 6'h23;
      tick(); tick(); tick(); chk("mid_s3", state0, 3);
      rst = 1'b1; #1; chk("mid_rst_en", en0, 4'b0000);
      tick(); chk("mid_rst_s0", state0, 0); chk("mid_rst_en2", en0, 4'b0000);
      tick(); tick();
      rst = 1'b0; #1; chk("mid_rel_en", en0, 4'b1100); chk("mid_rel_en1", en1, 4'b1100);

      // undefined opcode: both instances flag it, only the trapping one halts
      op = 6'h3F;
      tick(); chk("ill0_id", ill0, 1); chk("ill1_id", ill1, 1); chk("ill0_en", en0, 4'b0000);
      tick(); chk("ill0_s0", state0, 0); chk("ill1_halt", state1, 5); chk("ill1_en", en1, 4'b0000);
      tick(); tick(); tick();
      chk("halt_hold", state1, 5); chk("halt_en", en1, 4'b0000); chk("halt_ill", ill1, 0);

      // undefined R-type func behaves as undefined opcode
      rst = 1'b1; tick(); rst = 1'b0; #1;
      chk("rel_s1", state1, 0);
      op = 6'h00; func = 6'h3F;
      tick(); chk("illf_0", ill0, 1); chk("illf_1", ill1, 1);
      tick(); chk("illf_s0", state0, 0); chk("illf_halt", state1, 5);
      rst = 1'b1; tick(); rst = 1'b0; #1;
      chk("final_s1", state1, 0); chk("final_en1", en1, 4'b1100);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle control unit for the MIPS32 multicycle computer. It sequences one shared ALU and one unified instruction/data memory through fetch, decode, execute, memory and write-back states. It does this by issuing per-cycle write enables and mux selects to the datapath. It takes the place of the single-cycle combinational control and holds the only architectural sequencing state in the CPU.

## Interface
Parameters:
- ILL_TRAP, default 0: 0 = an undefined opcode retires as a NOP; 1 = an undefined opcode parks the FSM in sHALT until reset.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- op  in  6  inst[31:26] from the IR
- func  in  6  inst[5:0] from the IR
- z  in  1  ALU zero flag, current cycle
- wpc  out  1  PC write enable
- wir  out  1  IR write enable
- wmem  out  1  memory write enable
- wreg  out  1  register file write enable
- iord  out  1  memory address select: 0 = PC, 1 = ALU-out register
- regrt  out  1  destination register: 1 = rt, 0 = rd
- m2reg  out  1  write-back data: 1 = memory data register, 0 = ALU-out
- jal  out  1  force destination $31 and data = PC
- shift  out  1  ALU A = shamt
- sext  out  1  immediate sign-extend (0 = zero-extend)
- alusrca  out  1  ALU A: 0 = PC, 1 = rs
- alusrcb  out  2  ALU B: 00 = rt, 01 = 4, 10 = imm, 11 = imm<<2
- aluc  out  4  ALU opcode
- pcsource  out  2  next PC: 00 = ALU, 01 = ALU-out register (branch), 10 = rs, 11 = jump target
- state  out  3  current state, for debug
- ill  out  1  undefined instruction detected (ID state only)

## Operation
- Supported instructions: add, sub, and, or, xor, sll, srl, sra, jr, addi, andi, ori, xori, lw, sw, beq, bne, lui, j, jal.
- States (3-bit): sIF=0, sID=1, sEXE=2, sMEM=3, sWB=4, sHALT=5.
- sIF: wpc=1, wir=1, iord=0, alusrca=0, alusrcb=01, aluc=ADD, pcsource=00. Next state is sID.
- sID: alusrca=0, alusrcb=11, sext=1, aluc=ADD, which forms the branch target in the ALU-out register.
  - j: wpc=1, pcsource=11; next sIF.
  - jal: as j, plus wreg=1 and jal=1; next sIF.
  - jr: wpc=1, pcsource=10; next sIF.
  - Undefined opcode: ill=1; next sIF (ILL_TRAP=0) or sHALT (ILL_TRAP=1).
  - All other instructions: next sEXE.
- sEXE: alusrca=1, or shift=1 for sll/srl/sra. alusrcb=00 for R-type, 10 for I-type. sext=1 for addi/lw/sw/beq/bne, 0 for andi/ori/xori/lui. aluc per instruction.
  - beq/bne: aluc=SUB, pcsource=01, wpc=(beq&z)|(bne&~z); next sIF.
  - lw/sw: aluc=ADD; next sMEM.
  - All others: next sWB.
- sMEM: iord=1. sw: wmem=1, next sIF. lw: next sWB.
- sWB: wreg=1. regrt=1 for I-type. m2reg=1 for lw only. Next sIF.
- sHALT: all enables 0; the FSM stays in sHALT until rst.
- aluc codes: ADD 0000, SUB 0100, AND 0001, OR 0101, XOR 0010, LUI 0110, SLL 0011, SRL 0111, SRA 1111.
- R-type with undefined func is handled as an undefined opcode.
- Any output not listed for a state is 0.

## Timing
- Reset: rst sampled high loads state=sIF on that edge. While rst=1, wpc, wir, wmem, wreg and ill are forced to 0. The first fetch takes place in the cycle after rst falls.
- Reset mid-instruction aborts the instruction. No partial write is issued in the reset cycle.
- Outputs are combinational from state, op, func and z. The only register is state.
- Cycles per instruction: j/jal/jr = 2, beq/bne = 3, sw = 4, R-type/I-ALU = 4, lw = 5, undefined = 2.
- The branch decision uses z in the sEXE cycle. A not-taken branch advances the PC only via the sIF increment.

## Structure
- Package mc_pkg holds:
  - state encodings
  - op and func constants
  - aluc codes
  - alusrcb and pcsource select encodings
- Sub-module mc_decode is combinational. It maps op/func to one-hot instruction flags plus ill, is_rtype and is_itype. mc_ctrl holds the FSM and the per-state output logic.

## Test plan
- Reset: hold rst for 3 cycles mid-lw (state=sMEM) -> state=0 and all enables 0 during reset; the cycle after release has wpc=wir=1.
- add (op=0, func=0x20) -> states 0,1,2,4,0. In sEXE: aluc=0000, alusrcb=00. In sWB: wreg=1, regrt=0.
- lw then sw -> lw gives states 0,1,2,3,4 with iord=1 in sMEM and m2reg=1 in sWB. sw gives states 0,1,2,3 with wmem=1 only in sMEM.
- beq with z=1, then beq with z=0, then bne with z=0 -> wpc=1, 0, 1 respectively in sEXE, with pcsource=01 and aluc=0100.
- jal (op=0x03) -> 2 cycles; in sID: wpc=wreg=jal=1 and pcsource=11.
- Undefined op=0x3F -> ILL_TRAP=0: ill=1 in sID, then sIF. ILL_TRAP=1: state=5 held with no enables until rst.
